// File: rtl/sad_pkg.sv
// Shared definitions for the SAD stimulus driver: phase bounds of the
// in_valid burst, out_valid burst length, buffer select codes and FSM states.
package sad_pkg;

    // SEND cycle index bounds (exclusive upper ends of each phase)
    localparam logic [7:0] D1_END     = 8'd16;
    localparam logic [7:0] Q_END      = 8'd64;
    localparam logic [7:0] K_END      = 8'd128;
    localparam logic [7:0] V_END      = 8'd192;
    localparam logic [7:0] LAST_C     = 8'd191;

    localparam logic [6:0] OUT_CYCLES = 7'd64;
    localparam int         TIMEOUT_DEF = 1024;
    localparam logic [3:0] T_MAX      = 4'd8;

    typedef enum logic [2:0] {
        SEL_DATA1 = 3'd0,
        SEL_DATA2 = 3'd1,
        SEL_Q     = 3'd2,
        SEL_K     = 3'd3,
        SEL_V     = 3'd4
    } wr_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_RECV = 2'd3
    } state_e;

    function automatic logic t_legal(input logic [3:0] t);
        return (t != 4'd0) && (t <= T_MAX);
    endfunction

endpackage

// File: rtl/sad_frame_buf.sv
// Frame storage for one SAD input frame: 16x6 data1, 64x8 data2, Q, K, V.
// Write port with address decode, and a per-phase read mux that returns zero
// for any field whose phase is inactive at cycle index rd_c.
// Ports:
//   clk, rst        clock, async active-high reset (clears all storage)
//   we              qualified write strobe (top gates it with IDLE)
//   wr_sel/addr/data  write target select, element index, element value
//   rd_en           read enable; all read fields are 0 when low
//   rd_c, rd_t      SEND cycle index and token count for the read
//   rd_data1..rd_v  phase-gated read data
module sad_frame_buf
    import sad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] wr_sel,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    input  logic [7:0] rd_c,
    input  logic [3:0] rd_t,
    output logic [5:0] rd_data1,
    output logic [7:0] rd_data2,
    output logic [7:0] rd_q,
    output logic [7:0] rd_k,
    output logic [7:0] rd_v
);

    logic [5:0] mem1 [16];
    logic [7:0] mem2 [64];
    logic [7:0] memq [64];
    logic [7:0] memk [64];
    logic [7:0] memv [64];

    wr_sel_e    sel;
    logic [5:0] idx;
    logic       hit1, hit2, hitq, hitk, hitv;

    assign sel = wr_sel_e'(wr_sel);
    assign idx = rd_c[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem1[i] <= '0;
            for (int i = 0; i < 64; i++) begin
                mem2[i] <= '0;
                memq[i] <= '0;
                memk[i] <= '0;
                memv[i] <= '0;
            end
        end else if (we) begin
            case (sel)
                SEL_DATA1: mem1[wr_addr[3:0]] <= wr_data[5:0];
                SEL_DATA2: mem2[wr_addr]      <= wr_data;
                SEL_Q:     memq[wr_addr]      <= wr_data;
                SEL_K:     memk[wr_addr]      <= wr_data;
                SEL_V:     memv[wr_addr]      <= wr_data;
                default:   ;
            endcase
        end
    end

    // A write on the same edge that launches the frame must reach cycle 0,
    // so the read path forwards the in-flight write data.
    assign hit1 = we && (sel == SEL_DATA1) && (wr_addr[3:0] == rd_c[3:0]);
    assign hit2 = we && (sel == SEL_DATA2) && (wr_addr == idx);
    assign hitq = we && (sel == SEL_Q)     && (wr_addr == idx);
    assign hitk = we && (sel == SEL_K)     && (wr_addr == idx);
    assign hitv = we && (sel == SEL_V)     && (wr_addr == idx);

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        rd_q     = '0;
        rd_k     = '0;
        rd_v     = '0;
        if (rd_en) begin
            if (rd_c < D1_END)
                rd_data1 = hit1 ? wr_data[5:0] : mem1[rd_c[3:0]];
            if (rd_c < {1'b0, rd_t, 3'b000})
                rd_data2 = hit2 ? wr_data : mem2[idx];
            // K and V phases index with the low 6 bits, i.e. c-64 / c-128
            if (rd_c < Q_END)
                rd_q = hitq ? wr_data : memq[idx];
            else if (rd_c < K_END)
                rd_k = hitk ? wr_data : memk[idx];
            else if (rd_c < V_END)
                rd_v = hitv ? wr_data : memv[idx];
        end
    end

endmodule

// File: rtl/sad_stim_driver.sv
// Transmit side of the SAD input stream. Replays a buffered frame on the SAD
// input pins with fixed per-cycle phase timing, then checks the SAD out_valid
// burst to close the frame.
// Ports:
//   clk, rst                     clock, async active-high reset
//   wr_en/wr_sel/wr_addr/wr_data buffer loader (IDLE only)
//   t_cfg, start                 token count and launch (IDLE only)
//   dut_out_valid                SAD out_valid
//   busy, done, err              status (done/err are 1-cycle pulses)
//   in_valid, in_data1, T, in_data2, w_Q, w_K, w_V  registered SAD inputs
//
// state | meaning
// IDLE  | loader writes accepted, waiting for start
// SEND  | streaming frame, cnt = cycle index of the current outputs
// WAIT  | frame sent, down-counting the timeout until first out_valid
// RECV  | counting contiguous out_valid cycles in ocnt
module sad_stim_driver
    import sad_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_sel,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [3:0] t_cfg,
    input  logic       start,
    input  logic       dut_out_valid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       in_valid,
    output logic [5:0] in_data1,
    output logic [3:0] T,
    output logic [7:0] in_data2,
    output logic [7:0] w_Q,
    output logic [7:0] w_K,
    output logic [7:0] w_V
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [6:0]    ocnt_q, ocnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    t_lat_q, t_lat_d;
    logic          done_d, err_d;
    logic [3:0]    t_out_d;
    logic          rd_en;
    logic [7:0]    rd_c;
    logic [3:0]    rd_t;
    logic          buf_we;
    logic [5:0]    rd_data1;
    logic [7:0]    rd_data2, rd_q, rd_k, rd_v;

    assign busy   = (state_q != ST_IDLE);
    assign buf_we = wr_en && (state_q == ST_IDLE);

    sad_frame_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .we       (buf_we),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_c     (rd_c),
        .rd_t     (rd_t),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_q     (rd_q),
        .rd_k     (rd_k),
        .rd_v     (rd_v)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && t_legal(t_cfg)) state_d = ST_SEND;
            ST_SEND: if (cnt_q == LAST_C) state_d = ST_WAIT;
            ST_WAIT: begin
                if (dut_out_valid)      state_d = ST_RECV;
                else if (tmr_q == '0)   state_d = ST_IDLE;
            end
            ST_RECV: begin
                if (!dut_out_valid)                    state_d = ST_IDLE;
                else if (ocnt_q == OUT_CYCLES - 7'd1)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Computes the values the output registers take at the next edge, so the
    // read index is one ahead of cnt_q.
    always_comb begin
        cnt_d   = cnt_q;
        ocnt_d  = ocnt_q;
        tmr_d   = tmr_q;
        t_lat_d = t_lat_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        t_out_d = '0;
        rd_en   = 1'b0;
        rd_c    = '0;
        rd_t    = t_lat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (t_legal(t_cfg)) begin
                        cnt_d   = '0;
                        t_lat_d = t_cfg;
                        t_out_d = t_cfg;
                        rd_en   = 1'b1;
                        rd_t    = t_cfg;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (cnt_q == LAST_C) begin
                    tmr_d  = TMR_LOAD;
                    ocnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    rd_en = 1'b1;
                    rd_c  = cnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (dut_out_valid)     ocnt_d = 7'd1;
                else if (tmr_q == '0)  err_d  = 1'b1;
                else                   tmr_d  = tmr_q - 1'b1;
            end
            ST_RECV: begin
                if (!dut_out_valid) begin
                    err_d = 1'b1;
                end else begin
                    if (ocnt_q == OUT_CYCLES - 7'd1) done_d = 1'b1;
                    if (ocnt_q != 7'h7f) ocnt_d = ocnt_q + 7'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            ocnt_q   <= '0;
            tmr_q    <= '0;
            t_lat_q  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            in_valid <= 1'b0;
            T        <= '0;
            in_data1 <= '0;
            in_data2 <= '0;
            w_Q      <= '0;
            w_K      <= '0;
            w_V      <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ocnt_q   <= ocnt_d;
            tmr_q    <= tmr_d;
            t_lat_q  <= t_lat_d;
            done     <= done_d;
            err      <= err_d;
            in_valid <= rd_en;
            T        <= t_out_d;
            in_data1 <= rd_data1;
            in_data2 <= rd_data2;
            w_Q      <= rd_q;
            w_K      <= rd_k;
            w_V      <= rd_v;
        end
    end

endmodule

// File: tb/tb_sad_stim_driver.sv
module tb_sad_stim_driver;

    localparam int TIMEOUT = 1024;
    localparam int OUTC    = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_sel;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] t_cfg;
    logic       start;
    logic       dut_out_valid;
    logic       busy, done, err, in_valid;
    logic [5:0] in_data1;
    logic [3:0] T;
    logic [7:0] in_data2, w_Q, w_K, w_V;

    always #5 clk = ~clk;

    sad_stim_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .t_cfg         (t_cfg),
        .start         (start),
        .dut_out_valid (dut_out_valid),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .in_valid      (in_valid),
        .in_data1      (in_data1),
        .T             (T),
        .in_data2      (in_data2),
        .w_Q           (w_Q),
        .w_K           (w_K),
        .w_V           (w_V)
    );

    int checks = 0;
    int errors = 0;

    // Reference frame contents
    logic [5:0] m1 [16];
    logic [7:0] m2 [64];
    logic [7:0] mq [64];
    logic [7:0] mk [64];
    logic [7:0] mv [64];

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m1[i] = '0;
        for (int i = 0; i < 64; i++) begin
            m2[i] = '0; mq[i] = '0; mk[i] = '0; mv[i] = '0;
        end
    endtask

    task automatic model_write(input int sel, input int a, input int d);
        case (sel)
            0: m1[a % 16] = 6'(d);
            1: m2[a] = 8'(d);
            2: mq[a] = 8'(d);
            3: mk[a] = 8'(d);
            4: mv[a] = 8'(d);
            default: ;
        endcase
    endtask

    // Called at a negedge while the DUT is idle
    task automatic drive_write(input int sel, input int a, input int d);
        wr_en   = 1'b1;
        wr_sel  = 3'(sel);
        wr_addr = 6'(a);
        wr_data = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
        model_write(sel, a, d);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 64; k++)
            for (int s = 1; s <= 4; s++)
                drive_write(s, k, int'($urandom_range(0, 255)));
        for (int k = 0; k < 16; k++)
            drive_write(0, k, int'($urandom_range(0, 63)));
    endtask

    // {busy, in_valid, T, in_data1, in_data2, w_Q, w_K, w_V} during SEND cycle c
    function automatic logic [43:0] exp_vec(input int c, input int t);
        logic [3:0] te;
        logic [5:0] d1;
        logic [7:0] d2, q, k, v;
        te = (c == 0) ? 4'(t) : 4'd0;
        d1 = (c < 16) ? m1[c] : 6'd0;
        d2 = (c < 8 * t) ? m2[c] : 8'd0;
        q  = (c < 64) ? mq[c] : 8'd0;
        k  = (c >= 64 && c < 128) ? mk[c - 64] : 8'd0;
        v  = (c >= 128 && c < 192) ? mv[c - 128] : 8'd0;
        return {1'b1, 1'b1, te, d1, d2, q, k, v};
    endfunction

    function automatic logic [43:0] dut_vec();
        return {busy, in_valid, T, in_data1, in_data2, w_Q, w_K, w_V};
    endfunction

    // Starts at a negedge in IDLE; ends at the negedge of the first WAIT cycle
    task automatic send_frame(input int t, input bit same_wr, input bit junk);
        logic [43:0] e, g;
        int s, a, d;
        start = 1'b1;
        t_cfg = 4'(t);
        if (same_wr) begin
            s = int'($urandom_range(0, 4));
            a = int'($urandom_range(0, 63));
            d = int'($urandom_range(1, 255));
            wr_en = 1'b1; wr_sel = 3'(s); wr_addr = 6'(a); wr_data = 8'(d);
            model_write(s, a, d);
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 0; c < 192; c++) begin
            e = exp_vec(c, t);
            g = dut_vec();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL stream c=%0d t=%0d got=%h exp=%h", c, t, g, e);
            end
            if (junk) begin
                wr_en   = 1'($urandom_range(0, 1));
                wr_sel  = 3'($urandom_range(0, 4));
                wr_addr = 6'($urandom_range(0, 63));
                wr_data = 8'($urandom_range(0, 255));
                start   = 1'($urandom_range(0, 1));
                t_cfg   = 4'($urandom_range(1, 8));
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        start = 1'b0;
        checks++;
        if (in_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL send_end in_valid=%b busy=%b exp in_valid=0 busy=1", in_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec() !== 44'h0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset vec=%h done=%b err=%b exp all 0", dut_vec(), done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        model_clear();
    endtask

    task automatic test_done(input int gap);
        bit bad = 0;
        repeat (gap) @(negedge clk);
        for (int i = 0; i < OUTC; i++) begin
            dut_out_valid = 1'b1;
            @(negedge clk);
            if (i < OUTC - 1 && (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1)) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL recv_early status changed before 64th out_valid");
        end
        // out_valid still high in cycle 65: must be ignored
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL recv_done done=%b err=%b busy=%b exp 1 0 0", done, err, busy);
        end
        @(negedge clk);
        dut_out_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || in_valid !== 1'b0) begin
            errors++;
            $display("FAIL recv_after done=%b err=%b busy=%b in_valid=%b exp 0 0 0 0",
                     done, err, busy, in_valid);
        end
    endtask

    task automatic test_broken(input int gap, input int n);
        bit bad = 0;
        repeat (gap) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            dut_out_valid = 1'b1;
            @(negedge clk);
            if (done !== 1'b0 || err !== 1'b0) bad = 1;
        end
        dut_out_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bad || err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL broken err=%b done=%b busy=%b early=%b exp 1 0 0 0", err, done, busy, bad);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL broken_pulse err=%b done=%b exp 0 0", err, done);
        end
    endtask

    task automatic test_pattern();
        for (int k = 0; k < 64; k++) begin
            drive_write(1, k, k + 1);
            drive_write(2, k, k);
            drive_write(3, k, -k);
            drive_write(4, k, 2 * k);
            if (k < 16) drive_write(0, k, k);
        end
        send_frame(8, 1'b0, 1'b0);
        test_done(60);
    endtask

    task automatic test_t3();
        fill_random();
        send_frame(3, 1'b1, 1'b0);
        test_broken(int'($urandom_range(0, 100)), 30);
    endtask

    task automatic test_bad_t();
        int tv [3];
        tv[0] = 0; tv[1] = 9; tv[2] = int'($urandom_range(10, 15));
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            t_cfg = 4'(tv[i]);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || in_valid !== 1'b0) begin
                errors++;
                $display("FAIL bad_t t=%0d err=%b busy=%b in_valid=%b exp 1 0 0",
                         tv[i], err, busy, in_valid);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || in_valid !== 1'b0) begin
                errors++;
                $display("FAIL bad_t_after t=%0d err=%b busy=%b in_valid=%b exp 0 0 0",
                         tv[i], err, busy, in_valid);
            end
        end
    endtask

    task automatic test_timeout();
        int first = -1;
        fill_random();
        send_frame(int'($urandom_range(1, 8)), 1'b0, 1'b1);
        for (int n = 0; n < TIMEOUT + 8; n++) begin
            if (err === 1'b1) begin
                first = n;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (first != TIMEOUT || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout err_at=%0d busy=%b exp err_at=%0d busy=0", first, busy, TIMEOUT);
        end
        @(negedge clk);
        // dropped writes/starts during the busy frame must not show up here
        send_frame(int'($urandom_range(1, 8)), 1'b1, 1'b0);
        test_done(int'($urandom_range(0, 200)));
    endtask

    task automatic test_reset_mid();
        logic [43:0] e, g;
        int t;
        fill_random();
        t = int'($urandom_range(1, 8));
        start = 1'b1;
        t_cfg = 4'(t);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 100; c++) begin
            e = exp_vec(c, t);
            g = dut_vec();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mid_stream c=%0d got=%h exp=%h", c, g, e);
            end
            if (c < 100) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_valid !== 1'b0 || w_K !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst in_valid=%b w_K=%h busy=%b exp 0 00 0", in_valid, w_K, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        send_frame(int'($urandom_range(1, 8)), 1'b0, 1'b0);
        test_done(int'($urandom_range(0, 50)));
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_sel = '0;
        wr_addr = '0;
        wr_data = '0;
        t_cfg = '0;
        start = 1'b0;
        dut_out_valid = 1'b0;
        test_reset();
        test_pattern();
        test_t3();
        test_bad_t();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
